fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32: width of all PC/target buses.
REQ-002 SHALL have parameter CNT_WIDTH, default 32: width of fetch counter.
REQ-003 SHALL have ports:
- clk  in  1  single clock, all state on rising edge
- rstn  in  1  asynchronous, active-low reset
- start  in  1  leave IDLE/HALTED
- halt_req  in  1  level, stop fetching at next safe point
- exc_valid  in  1  exception redirect request
- exc_target  in  PC_WIDTH  exception target
- br_valid  in  1  branch redirect request
- br_target  in  PC_WIDTH  branch target
- exc_ack, br_ack  out  1 each  redirect accepted this cycle
- imem_req  out  1  fetch request
- imem_gnt  in  1  request accepted
- imem_rsp_valid  in  1  fetch response
- dec_ready  in  1  decode can accept response
- fetch_valid  out  1  response forwarded to decode
- pc_load, pc_inc, pc_stall  out  1 each  program counter controls
- pc_load_value  out  PC_WIDTH  program counter load data
- flush  out  1  redirect discarded in-flight fetch
- fetch_cnt  out  CNT_WIDTH  forwarded-fetch count, wraps
- state_o  out  3  FSM state (debug)

Function
REQ-004 FSM states SHALL be: IDLE, FETCH, WAIT_RSP, HOLD, HALTED.
REQ-005 IDLE/HALTED: pc_stall=1, imem_req=0; start -> FETCH; redirects ignored, acks 0.
REQ-006 FETCH: imem_req = !discard; imem_req & imem_gnt -> WAIT_RSP.
REQ-007 FETCH with halt_req=1, discard=0, no redirect -> HALTED, imem_req=0 that cycle.
REQ-008 WAIT_RSP: rsp_valid & dec_ready -> fetch_valid=1, pc_inc=1, -> FETCH; rsp_valid & !dec_ready -> HOLD.
REQ-009 HOLD: pc_stall=1, fetch_valid=dec_ready; dec_ready -> pc_inc=1, -> FETCH.
REQ-010 Redirect SHALL be accepted in FETCH, WAIT_RSP, HOLD: pc_load=1, same-cycle ack, next state FETCH.
REQ-011 Priority exc > br; both valid -> exc_ack=1, br_ack=0, pc_load_value=exc_target.
REQ-012 pc_load_value SHALL be 0 when pc_load=0.
REQ-013 Redirect in WAIT_RSP without rsp_valid, or in FETCH coincident with imem_gnt, SHALL set discard=1 and pulse flush=1.
REQ-014 Redirect in WAIT_RSP coincident with rsp_valid SHALL drop that response (fetch_valid=0), discard stays 0, flush=1.
REQ-015 Redirect in HOLD SHALL drop the held response, flush=1, no discard.
REQ-016 While discard=1, imem_rsp_valid SHALL clear discard and produce fetch_valid=0.
REQ-017 Redirect SHALL take priority over halt_req, pc_inc and HOLD.
REQ-018 At most one of pc_load, pc_inc, pc_stall SHALL be high in any cycle.
REQ-019 fetch_cnt SHALL increment by 1 per fetch_valid, wrapping 2^CNT_WIDTH-1 -> 0.
REQ-020 All outputs other than fetch_cnt, state_o SHALL be combinational from state and inputs; one outstanding fetch maximum.

Reset
REQ-021 rstn low SHALL asynchronously force state IDLE, discard 0, fetch_cnt 0.
REQ-022 During reset, outputs SHALL be: pc_stall=1, all other control outputs 0, pc_load_value 0, state_o IDLE encoding.
REQ-023 Reset mid-fetch SHALL abandon outstanding request; no discard persists across reset.

Structure
REQ-024 Package fetch_sequencer_pkg SHALL hold the state enum fetch_state_e (IDLE=0, FETCH=1, WAIT_RSP=2, HOLD=3, HALTED=4) and default widths.
REQ-025 No sub-module: program_counter instance lives in the parent fetch stage; redirect mux, discard flag and counter are inline.

Verification
REQ-026 Reset, start, gnt immediate, rsp next cycle, dec_ready=1 -> fetch_valid one cycle, pc_inc one cycle, fetch_cnt=1.
REQ-027 Rsp with dec_ready=0 for 3 cycles -> HOLD, pc_stall=1 three cycles, then pc_inc + fetch_valid when ready.
REQ-028 exc_valid+br_valid together in WAIT_RSP, exc_target=0x100, br_target=0x200 -> pc_load_value=0x100, exc_ack=1, br_ack=0, flush=1, next rsp dropped, imem_req low until it arrives.
REQ-029 halt_req in FETCH -> HALTED, imem_req=0; start -> FETCH, fetch resumes.
REQ-030 CNT_WIDTH=4, 17 forwarded fetches -> fetch_cnt=1; rstn low mid WAIT_RSP -> IDLE, counter 0 immediately.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and default widths for the instruction fetch sequencer.
package fetch_sequencer_pkg;

  localparam int PC_WIDTH_DEF  = 32;
  localparam int CNT_WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    WAIT_RSP = 3'd2,
    HOLD     = 3'd3,
    HALTED   = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: issues one instruction-memory request at a time, forwards
// responses to decode, handles exception/branch redirects and halt.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int PC_WIDTH  = PC_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 halt_req,
  input  logic                 exc_valid,
  input  logic [PC_WIDTH-1:0]  exc_target,
  input  logic                 br_valid,
  input  logic [PC_WIDTH-1:0]  br_target,
  output logic                 exc_ack,
  output logic                 br_ack,
  output logic                 imem_req,
  input  logic                 imem_gnt,
  input  logic                 imem_rsp_valid,
  input  logic                 dec_ready,
  output logic                 fetch_valid,
  output logic                 pc_load,
  output logic                 pc_inc,
  output logic                 pc_stall,
  output logic [PC_WIDTH-1:0]  pc_load_value,
  output logic                 flush,
  output logic [CNT_WIDTH-1:0] fetch_cnt,
  output logic [2:0]           state_o
);

  fetch_state_e         state_q, state_d;
  logic                 discard_q, discard_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 redir;
  logic [PC_WIDTH-1:0]  redir_tgt;

  assign redir     = exc_valid | br_valid;
  assign redir_tgt = exc_valid ? exc_target : br_target;

  always_comb begin
    state_d       = state_q;
    discard_d     = discard_q;
    exc_ack       = 1'b0;
    br_ack        = 1'b0;
    imem_req      = 1'b0;
    fetch_valid   = 1'b0;
    pc_load       = 1'b0;
    pc_inc        = 1'b0;
    pc_stall      = 1'b0;
    pc_load_value = '0;
    flush         = 1'b0;

    // Redirect acceptance is common to every active state.
    if (redir && (state_q == FETCH || state_q == WAIT_RSP || state_q == HOLD)) begin
      pc_load       = 1'b1;
      pc_load_value = redir_tgt;
      exc_ack       = exc_valid;
      br_ack        = ~exc_valid;
    end

    unique case (state_q)
      IDLE, HALTED: begin
        pc_stall = 1'b1;
        if (start) state_d = FETCH;
      end
      FETCH: begin
        imem_req = ~discard_q;
        // A response for a discarded request is swallowed, never forwarded.
        if (discard_q && imem_rsp_valid) discard_d = 1'b0;
        if (redir) begin
          state_d = FETCH;
          if (!discard_q && imem_gnt) begin
            discard_d = 1'b1;
            flush     = 1'b1;
          end
        end else if (halt_req && !discard_q) begin
          imem_req = 1'b0;
          state_d  = HALTED;
        end else if (!discard_q && imem_gnt) begin
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (redir) begin
          flush   = 1'b1;
          state_d = FETCH;
          if (!imem_rsp_valid) discard_d = 1'b1;
        end else if (imem_rsp_valid) begin
          if (dec_ready) begin
            fetch_valid = 1'b1;
            pc_inc      = 1'b1;
            state_d     = FETCH;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (redir) begin
          flush   = 1'b1;
          state_d = FETCH;
        end else if (dec_ready) begin
          fetch_valid = 1'b1;
          pc_inc      = 1'b1;
          state_d     = FETCH;
        end else begin
          pc_stall = 1'b1;
        end
      end
      default: begin
        pc_stall = 1'b1;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      discard_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      if (fetch_valid) cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign fetch_cnt = cnt_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a 4-bit fetch counter.
module tb_fetch_sequencer;

  localparam int PW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start, halt_req, exc_valid, br_valid;
  logic [PW-1:0] exc_target, br_target;
  logic          exc_ack, br_ack, imem_req, imem_gnt, imem_rsp_valid, dec_ready;
  logic          fetch_valid, pc_load, pc_inc, pc_stall, flush;
  logic [PW-1:0] pc_load_value;
  logic [CW-1:0] fetch_cnt;
  logic [2:0]    state_o;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.PC_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .halt_req(halt_req),
    .exc_valid(exc_valid), .exc_target(exc_target),
    .br_valid(br_valid), .br_target(br_target),
    .exc_ack(exc_ack), .br_ack(br_ack),
    .imem_req(imem_req), .imem_gnt(imem_gnt), .imem_rsp_valid(imem_rsp_valid),
    .dec_ready(dec_ready), .fetch_valid(fetch_valid),
    .pc_load(pc_load), .pc_inc(pc_inc), .pc_stall(pc_stall),
    .pc_load_value(pc_load_value), .flush(flush),
    .fetch_cnt(fetch_cnt), .state_o(state_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, where inputs are changed.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rstn = 1'b0; start = 0; halt_req = 0; exc_valid = 1; br_valid = 0;
    exc_target = 32'h44; br_target = '0; imem_gnt = 0; imem_rsp_valid = 0; dec_ready = 0;
    settle();
    chk("rst_state", state_o, 0);
    chk("rst_stall", pc_stall, 1);
    chk("rst_req", imem_req, 0);
    chk("rst_cnt", fetch_cnt, 0);
    chk("rst_ack", exc_ack, 0);
    chk("rst_load", {pc_load, pc_inc, flush, fetch_valid}, 0);
    chk("rst_plv", pc_load_value, 0);

    cyc(); rstn = 1'b1; start = 1; settle();
    chk("idle_stall", pc_stall, 1);
    chk("idle_exc_ign", {exc_ack, pc_load}, 0);

    // Basic fetch: grant immediately, response next cycle, decode ready.
    cyc(); start = 0; exc_valid = 0; imem_gnt = 1; settle();
    chk("f1_state", state_o, 1);
    chk("f1_req", imem_req, 1);
    chk("f1_stall", pc_stall, 0);
    cyc(); imem_gnt = 0; imem_rsp_valid = 1; dec_ready = 1; settle();
    chk("f1_wait", state_o, 2);
    chk("f1_fv_inc", {fetch_valid, pc_inc, imem_req}, 3'b110);
    cyc(); imem_rsp_valid = 0; dec_ready = 0; imem_gnt = 1; settle();
    chk("f1_cnt", fetch_cnt, 1);
    chk("f1_fv_off", {fetch_valid, pc_inc}, 0);

    // Decode back-pressure for three cycles.
    cyc(); imem_gnt = 0; imem_rsp_valid = 1; settle();
    chk("h_rsp_nofv", {fetch_valid, pc_inc}, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(); imem_rsp_valid = 0; settle();
      chk("h_state", state_o, 3);
      chk("h_stall_fv", {pc_stall, fetch_valid, pc_inc}, 3'b100);
    end
    cyc(); dec_ready = 1; settle();
    chk("h_release", {fetch_valid, pc_inc, pc_stall}, 3'b110);

    // Simultaneous exception and branch while waiting for a response.
    cyc(); dec_ready = 0; imem_gnt = 1; settle();
    chk("r_cnt2", fetch_cnt, 2);
    cyc(); imem_gnt = 0; exc_valid = 1; exc_target = 32'h100;
    br_valid = 1; br_target = 32'h200; settle();
    chk("r_plv", pc_load_value, 32'h100);
    chk("r_acks", {exc_ack, br_ack, flush, pc_load, pc_inc}, 5'b10110);
    cyc(); exc_valid = 0; br_valid = 0; imem_gnt = 1; settle();
    chk("r_state", state_o, 1);
    chk("r_req_blk", imem_req, 0);
    chk("r_plv0", {pc_load_value, flush}, 0);
    cyc(); imem_gnt = 0; imem_rsp_valid = 1; dec_ready = 1; settle();
    chk("r_drop", {fetch_valid, imem_req}, 0);

    // Halt at a safe point, then restart.
    cyc(); imem_rsp_valid = 0; dec_ready = 0; halt_req = 1; settle();
    chk("hl_req", imem_req, 0);
    chk("hl_cnt", fetch_cnt, 2);
    cyc(); start = 1; settle();
    chk("hl_state", state_o, 4);
    chk("hl_stall", {pc_stall, imem_req}, 2'b10);
    cyc(); start = 0; halt_req = 0; imem_gnt = 1; settle();
    chk("hl_resume", {state_o, imem_req}, 4'b0011);

    // Redirect coincident with a response: drop it, no discard.
    cyc(); imem_gnt = 0; imem_rsp_valid = 1; dec_ready = 1; br_valid = 1; br_target = 32'h200; settle();
    chk("rr_drop", {fetch_valid, flush, br_ack, pc_inc}, 4'b0110);
    chk("rr_plv", pc_load_value, 32'h200);

    // Redirect in FETCH coincident with a grant: discard set.
    cyc(); imem_rsp_valid = 0; dec_ready = 0; imem_gnt = 1; br_target = 32'h300; settle();
    chk("fg_req", imem_req, 1);
    chk("fg_flush", {flush, pc_load, br_ack}, 3'b111);
    chk("fg_plv", pc_load_value, 32'h300);
    cyc(); imem_gnt = 0; br_valid = 0; settle();
    chk("fg_blk", {state_o, imem_req}, 4'b0010);
    cyc(); imem_rsp_valid = 1; dec_ready = 1; settle();
    chk("fg_drop", fetch_valid, 0);

    // Redirect while holding a response.
    cyc(); imem_rsp_valid = 0; dec_ready = 0; imem_gnt = 1; settle();
    chk("hr_req", imem_req, 1);
    cyc(); imem_gnt = 0; imem_rsp_valid = 1; settle();
    cyc(); imem_rsp_valid = 0; exc_valid = 1; exc_target = 32'h40; dec_ready = 1; halt_req = 1; settle();
    chk("hr_drop", {fetch_valid, pc_load, flush, pc_inc, pc_stall}, 5'b01100);
    chk("hr_plv", pc_load_value, 32'h40);
    cyc(); exc_valid = 0; halt_req = 0; dec_ready = 0; settle();
    chk("hr_nodisc", {state_o, imem_req}, 4'b0011);
    chk("hr_cnt", fetch_cnt, 2);

    // Counter wrap: 14 more fetches reach 16 -> 0, one more gives 1.
    for (int i = 0; i < 15; i++) begin
      imem_gnt = 1;
      cyc(); imem_gnt = 0; imem_rsp_valid = 1; dec_ready = 1;
      cyc(); imem_rsp_valid = 0; dec_ready = 0;
      if (i == 13) begin
        settle();
        chk("wrap0", fetch_cnt, 0);
      end
    end
    settle();
    chk("wrap1", fetch_cnt, 1);

    // Asynchronous reset in the middle of an outstanding fetch.
    imem_gnt = 1;
    cyc(); imem_gnt = 0; settle();
    chk("ar_wait", state_o, 2);
    #2 rstn = 1'b0; settle();
    chk("ar_state", state_o, 0);
    chk("ar_cnt", fetch_cnt, 0);
    chk("ar_ctl", {pc_stall, imem_req, fetch_valid}, 3'b100);
    cyc(); rstn = 1'b1; start = 1; settle();
    cyc(); start = 0; settle();
    chk("ar_nodisc", {state_o, imem_req}, 4'b0011);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
